input_event_arbiter: RTL and testbench
======================================

// Module: input_event_arbiter
// PURPOSE
//  Front-end controller for the vending machine's coin and selection buttons.
//  - Synchronises and debounces N_IN raw inputs, each with its own stability counter.
//  - Turns each debounced rising edge into a pending event.
//  - Round-robin arbitrates the pending events onto one valid/ready event port.
//  - The port feeds the vending FSM, so simultaneous presses are never lost silently.
// PARAMETERS
//  N_IN      4   number of raw inputs (0=coin5, 1=coin10, 2=selA, 3=selB)
//  DB_CYCLES 4   consecutive cycles a changed level must persist; legal range 2 .. 2^CNT_W-1
//  CNT_W     20  debounce counter width
//  ID_W is a localparam = $clog2(N_IN).
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       synchronous reset, active-low
//  raw_in     in   N_IN    asynchronous button/coin levels, active-high
//  evt_ready  in   1       consumer accepts the event when high with evt_valid
//  err_clr    in   1       one-cycle pulse that clears drop_err
//  evt_valid  out  1       event present on evt_id
//  evt_id     out  ID_W    index of the input that produced the event
//  btn_level  out  N_IN    debounced level per input
//  drop_err   out  1       sticky flag: an event was lost
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//  - sync flops, cnt, btn_level, pending, evt_valid, evt_id and drop_err all go to 0.
//  - The round-robin pointer goes to N_IN-1, so channel 0 has first priority.
//  - An input held high through reset release is debounced and reported as a new event.
//  Synchroniser: two flops per input, s1 <= raw_in, s2 <= s1.
//  Debounce, per channel:
//  - s2 == btn_level: cnt <= 0.
//  - s2 != btn_level and cnt < DB_CYCLES-1: cnt <= cnt+1.
//  - s2 != btn_level and cnt == DB_CYCLES-1: btn_level <= s2, cnt <= 0.
//  - Any bounce back before terminal count restarts cnt at 0.
//  Edge detect: a btn_level 0->1 update is a rise event; falling updates produce no event.
//  Pending bits:
//  - A rise event sets pending[i] at the same edge btn_level rises.
//  - A grant to channel i clears pending[i].
//  - A rise on i in the same cycle as i's grant leaves pending[i] set; the new event is kept.
//  - A rise on i while pending[i]=1 and i is not granted that cycle sets drop_err.
//  drop_err: stays set until rst_n or err_clr; a set and a clear in the same cycle resolve as set.
//  Arbiter:
//  - A slot is free when evt_valid==0, or evt_valid && evt_ready.
//  - In a free-slot cycle with any pending bit set, the arbiter picks the first set pending
//    bit searching from ptr+1 upward, modulo N_IN.
//  - At that edge: evt_valid <= 1, evt_id <= winner, ptr <= winner, pending[winner] <= 0.
//  - Slot free and nothing pending: evt_valid <= 0, evt_id holds its value.
//  - evt_valid && !evt_ready: evt_valid and evt_id hold, and no grant occurs.
//  - Back-to-back: with ready held high and events pending, one event is issued per cycle.
//  Latency: raw rise sampled at edge 0 with the channel idle and the slot free ->
//    btn_level high after edge DB_CYCLES+1, evt_valid high after edge DB_CYCLES+2.
//  Reset mid-operation discards pending and in-flight events; no partial event is issued.
// TESTING
//  1. Clean press, DB_CYCLES=4: raw_in[1] rises at edge 0 and holds -> btn_level[1]=1 after
//     edge 5; evt_valid=1, evt_id=1 after edge 6; evt_ready=1 -> evt_valid=0 after edge 7.
//  2. Bounce: raw_in[0] toggles 1,0,1,0 on successive cycles, then stays 0 -> btn_level
//     stays 0, no event, cnt returns to 0.
//  3. Simultaneous: raw_in[3:0]=4'b1111 at once, evt_ready=1 -> events come out in id order
//     0,1,2,3 on consecutive cycles; next simultaneous burst after ptr=3 starts again at 0.
//  4. Backpressure: evt_ready=0 for 10 cycles with event id=2 valid -> evt_valid and evt_id
//     hold 2 throughout; the channel-0 press arriving meanwhile is issued right after acceptance.
//  5. Drop: press/release/press ch1 twice while ch1 is pending and evt_ready=0 ->
//     drop_err=1 and only one ch1 event is delivered; err_clr pulse -> drop_err=0.
//  6. Reset mid-debounce and with evt_valid=1: rst_n low for 1 cycle -> all outputs 0 the
//     next cycle; raw_in still high -> fresh event DB_CYCLES+2 cycles after reset release.

Source files
------------

// File: rtl/input_event_arbiter.sv
// Coin/selection front end: synchronises and debounces raw inputs, latches rising edges
// as pending events and round-robin issues them on a single valid/ready event port.
module input_event_arbiter #(
  parameter int N_IN      = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20,
  localparam int ID_W     = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  input  logic            evt_ready,
  input  logic            err_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_IN-1:0] btn_level,
  output logic            drop_err
);

  logic [N_IN-1:0]  s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [N_IN-1:0]  lvl_q, lvl_d;
  logic [N_IN-1:0]  pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  grant_vec;
  logic             slot_free;
  logic             found;
  logic [ID_W-1:0]  win;

  // A changed level must be seen DB_CYCLES consecutive samples before it is accepted.
  always_comb begin
    lvl_d = lvl_q;
    rise  = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          lvl_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = (int'(ptr_q) + k) % N_IN;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    slot_free = !valid_q || evt_ready;
    grant_vec = '0;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    if (slot_free) begin
      valid_d = found;
      if (found) begin
        grant_vec[win] = 1'b1;
        id_d           = win;
        ptr_d          = win;
      end
    end
    // A fresh rise on a channel being granted this cycle survives as the next event.
    pend_d = (pend_q & ~grant_vec) | rise;
    err_d  = (|(rise & pend_q & ~grant_vec)) | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= ID_W'(N_IN - 1);
      err_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign btn_level = lvl_q;
  assign drop_err  = err_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Bench for input_event_arbiter: directed scenarios with literal expectations, then random
// stimulus, all compared each cycle against a window-based behavioural model.
module tb_input_event_arbiter;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int CW = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw_in;
  logic         evt_ready;
  logic         err_clr;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] btn_level;
  logic         drop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_event_arbiter #(.N_IN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .evt_ready (evt_ready),
    .err_clr   (err_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .btn_level (btn_level),
    .drop_err  (drop_err)
  );

  // Model: a level flips once the last DB synchronised samples all disagree with it.
  bit           modelReady = 1'b0;
  logic [N-1:0] mS1, mS2, mLvl, mPend;
  logic [N-1:0] mWin [DB];
  logic         mValid, mErr;
  logic [1:0]   mId;
  int           mPtr;

  always @(posedge clk) begin : model
    logic [N-1:0] mRise, mGrant;
    logic         mFree, mErrSet;
    bit           allDiff;
    int           idx;
    if (!rst_n) begin
      mS1 = '0; mS2 = '0; mLvl = '0; mPend = '0;
      mValid = 1'b0; mErr = 1'b0; mId = '0; mPtr = N - 1;
      for (int j = 0; j < DB; j++) mWin[j] = '0;
      modelReady = 1'b1;
    end else begin
      for (int j = DB - 1; j > 0; j--) mWin[j] = mWin[j-1];
      mWin[0] = mS2;
      mRise = '0;
      for (int i = 0; i < N; i++) begin
        allDiff = 1'b1;
        for (int j = 0; j < DB; j++) if (mWin[j][i] == mLvl[i]) allDiff = 1'b0;
        if (allDiff) begin
          mLvl[i] = ~mLvl[i];
          if (mLvl[i]) mRise[i] = 1'b1;
        end
      end
      mS2 = mS1;
      mS1 = raw_in;
      mFree  = !mValid || evt_ready;
      mGrant = '0;
      if (mFree) begin
        mValid = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (mPtr + k) % N;
          if (mGrant == '0 && mPend[idx]) begin
            mGrant[idx] = 1'b1;
            mValid = 1'b1;
            mId = 2'(idx);
            mPtr = idx;
          end
        end
      end
      mErrSet = |(mRise & mPend & ~mGrant);
      mPend   = (mPend & ~mGrant) | mRise;
      mErr    = mErrSet || (mErr && !err_clr);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    if (modelReady) begin
      checkOutput("evt_valid", 32'(evt_valid), 32'(mValid));
      if (mValid) checkOutput("evt_id", 32'(evt_id), 32'(mId));
      checkOutput("btn_level", 32'(btn_level), 32'(mLvl));
      checkOutput("drop_err", 32'(drop_err), 32'(mErr));
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic rdy, input logic clr, input logic rn);
    @(negedge clk);
    compareModel();
    raw_in    = r;
    evt_ready = rdy;
    err_clr   = clr;
    rst_n     = rn;
  endtask

  task automatic holdFor(input int n, input logic [N-1:0] r, input logic rdy);
    repeat (n) applyStimulus(r, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0; raw_in = '0; evt_ready = 1'b0; err_clr = 1'b0;
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_level", 32'(btn_level), 32'd0);
    checkOutput("rst_err", 32'(drop_err), 32'd0);
    holdFor(3, 4'h0, 1'b1);

    // Simultaneous presses drain in id order starting at 0.
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
    holdFor(6, 4'hF, 1'b1);
    checkOutput("sim_level", 32'(btn_level), 32'hF);
    checkOutput("sim_novalid", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
      checkOutput("sim_valid", 32'(evt_valid), 32'd1);
      checkOutput("sim_id", 32'(evt_id), 32'(k));
    end
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
    checkOutput("sim_done", 32'(evt_valid), 32'd0);
    holdFor(8, 4'h0, 1'b1);
    checkOutput("sim_release", 32'(btn_level), 32'd0);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
    holdFor(7, 4'hF, 1'b1);
    checkOutput("sim2_id", 32'(evt_id), 32'd0);
    holdFor(4, 4'hF, 1'b1);
    checkOutput("sim2_done", 32'(evt_valid), 32'd0);
    holdFor(8, 4'h0, 1'b1);

    // Clean press latency on channel 1.
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b1);
    holdFor(6, 4'h2, 1'b1);
    checkOutput("press_level", 32'(btn_level), 32'h2);
    checkOutput("press_model_level", 32'(mLvl), 32'h2);
    checkOutput("press_early", 32'(evt_valid), 32'd0);
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b1);
    checkOutput("press_valid", 32'(evt_valid), 32'd1);
    checkOutput("press_id", 32'(evt_id), 32'd1);
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b1);
    checkOutput("press_accept", 32'(evt_valid), 32'd0);
    holdFor(8, 4'h0, 1'b1);

    // Bounce must not produce a level change, and must leave the counter idle.
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
    holdFor(8, 4'h0, 1'b1);
    checkOutput("bounce_level", 32'(btn_level), 32'd0);
    checkOutput("bounce_valid", 32'(evt_valid), 32'd0);
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b1);
    holdFor(5, 4'h1, 1'b1);
    checkOutput("bounce_after_e4", 32'(btn_level), 32'h0);
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b1);
    checkOutput("bounce_after_e5", 32'(btn_level), 32'h1);
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b1);
    checkOutput("bounce_evt_id", 32'(evt_id), 32'd0);
    holdFor(8, 4'h0, 1'b1);

    // Backpressure holds id 2 while a channel-0 event waits.
    applyStimulus(4'h4, 1'b0, 1'b0, 1'b1);
    holdFor(7, 4'h4, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'h5, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_valid", 32'(evt_valid), 32'd1);
      checkOutput("bp_id", 32'(evt_id), 32'd2);
    end
    applyStimulus(4'h5, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h5, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_next_valid", 32'(evt_valid), 32'd1);
    checkOutput("bp_next_id", 32'(evt_id), 32'd0);
    applyStimulus(4'h5, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_drained", 32'(evt_valid), 32'd0);
    holdFor(8, 4'h0, 1'b1);

    // Second ch1 rise while ch1 is still pending is dropped and flagged.
    applyStimulus(4'h8, 1'b0, 1'b0, 1'b1);
    holdFor(7, 4'h8, 1'b0);
    holdFor(8, 4'hA, 1'b0);
    checkOutput("drop_none_yet", 32'(drop_err), 32'd0);
    holdFor(8, 4'h8, 1'b0);
    holdFor(8, 4'hA, 1'b0);
    checkOutput("drop_set", 32'(drop_err), 32'd1);
    applyStimulus(4'hA, 1'b1, 1'b0, 1'b1);
    checkOutput("drop_held_id", 32'(evt_id), 32'd3);
    applyStimulus(4'hA, 1'b1, 1'b0, 1'b1);
    checkOutput("drop_ch1_id", 32'(evt_id), 32'd1);
    applyStimulus(4'hA, 1'b1, 1'b1, 1'b1);
    checkOutput("drop_single", 32'(evt_valid), 32'd0);
    checkOutput("drop_sticky", 32'(drop_err), 32'd1);
    applyStimulus(4'hA, 1'b1, 1'b0, 1'b1);
    checkOutput("drop_cleared", 32'(drop_err), 32'd0);
    holdFor(8, 4'h0, 1'b1);

    // Reset with an event in flight and a press mid-debounce.
    applyStimulus(4'h4, 1'b0, 1'b0, 1'b1);
    holdFor(7, 4'h4, 1'b0);
    holdFor(3, 4'h5, 1'b0);
    applyStimulus(4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h5, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("mid_rst_id", 32'(evt_id), 32'd0);
    checkOutput("mid_rst_level", 32'(btn_level), 32'd0);
    holdFor(6, 4'h5, 1'b0);
    checkOutput("mid_rst_level2", 32'(btn_level), 32'h5);
    checkOutput("mid_rst_early", 32'(evt_valid), 32'd0);
    applyStimulus(4'h5, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_fresh", 32'(evt_valid), 32'd1);
    checkOutput("mid_rst_fresh_id", 32'(evt_id), 32'd0);
    holdFor(4, 4'h5, 1'b1);
    holdFor(8, 4'h0, 1'b1);

    // Random traffic: slow-changing raw levels give both real presses and bounces.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(11) == 0) r[b] = ~r[b];
      applyStimulus(r, $urandom_range(9) < 7, $urandom_range(39) == 0, $urandom_range(599) != 0);
    end
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
